// File: rtl/alu_exec_unit.sv
// Integer execute unit fed by the ALU reservation station. Single-cycle ALU
// ops, a multi-cycle Mul, and a result register that requests the CDB until granted.
module alu_exec_unit #(
  parameter int MUL_LATENCY = 3,
  parameter int ROB_IX_W    = 3
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                flush_in,
  input  logic                valid_in,
  input  logic [31:0]         rval1_in,
  input  logic [31:0]         rval2_in,
  input  logic [3:0]          opcode_in,
  input  logic [ROB_IX_W-1:0] rob_ix_in,
  output logic                fu_busy_out,
  output logic                cdb_req_out,
  input  logic                cdb_grant_in,
  output logic [31:0]         cdb_value_out,
  output logic [ROB_IX_W-1:0] cdb_rob_ix_out,
  output logic                drop_err_out
);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT_CDB} state_t;

  localparam logic [3:0] OP_MUL         = 4'd10;
  localparam logic [3:0] MUL_COUNT_INIT = 4'(MUL_LATENCY - 1);

  state_t      state;
  logic [3:0]  count;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic [31:0] mul_result;

  // Low 32 bits of a product are the same for signed and unsigned operands.
  always_comb begin
    alu_result = '0;
    case (opcode_in)
      4'd0:    alu_result = rval1_in + rval2_in;
      4'd1:    alu_result = rval1_in - rval2_in;
      4'd2:    alu_result = rval1_in & rval2_in;
      4'd3:    alu_result = rval1_in | rval2_in;
      4'd4:    alu_result = rval1_in ^ rval2_in;
      4'd5:    alu_result = {31'b0, $signed(rval1_in) < $signed(rval2_in)};
      4'd6:    alu_result = {31'b0, rval1_in < rval2_in};
      4'd7:    alu_result = rval1_in << rval2_in[4:0];
      4'd8:    alu_result = rval1_in >> rval2_in[4:0];
      4'd9:    alu_result = $signed(rval1_in) >>> rval2_in[4:0];
      4'd10:   alu_result = rval1_in * rval2_in;
      default: alu_result = '0;
    endcase
  end

  assign mul_result  = op_a * op_b;
  assign fu_busy_out = (state != IDLE);
  assign cdb_req_out = (state == WAIT_CDB);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= IDLE;
      count          <= '0;
      op_a           <= '0;
      op_b           <= '0;
      cdb_value_out  <= '0;
      cdb_rob_ix_out <= '0;
      drop_err_out   <= 1'b0;
    end else if (flush_in) begin
      // A flush coinciding with a grant still completes that transfer.
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in) begin
            cdb_rob_ix_out <= rob_ix_in;
            if (opcode_in == OP_MUL && MUL_LATENCY > 1) begin
              op_a  <= rval1_in;
              op_b  <= rval2_in;
              count <= MUL_COUNT_INIT;
              state <= EXEC;
            end else begin
              cdb_value_out <= alu_result;
              state         <= WAIT_CDB;
            end
          end
        end
        EXEC: begin
          if (valid_in) drop_err_out <= 1'b1;
          count <= count - 4'd1;
          if (count == 4'd1) begin
            cdb_value_out <= mul_result;
            state         <= WAIT_CDB;
          end
        end
        WAIT_CDB: begin
          if (valid_in) drop_err_out <= 1'b1;
          if (cdb_grant_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases with literal results
// plus randomized traffic checked every cycle against a transaction-level model.
module tb_alu_exec_unit;

  localparam int ML = 3;
  localparam int RW = 3;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          flush_in = 1'b0;
  logic          valid_in = 1'b0;
  logic [31:0]   rval1_in = '0;
  logic [31:0]   rval2_in = '0;
  logic [3:0]    opcode_in = '0;
  logic [RW-1:0] rob_ix_in = '0;
  logic          cdb_grant_in = 1'b0;
  logic          fu_busy_out;
  logic          cdb_req_out;
  logic [31:0]   cdb_value_out;
  logic [RW-1:0] cdb_rob_ix_out;
  logic          drop_err_out;

  int n_cmp = 0;
  int n_err = 0;

  alu_exec_unit #(.MUL_LATENCY(ML), .ROB_IX_W(RW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in), .valid_in(valid_in),
    .rval1_in(rval1_in), .rval2_in(rval2_in), .opcode_in(opcode_in),
    .rob_ix_in(rob_ix_in), .fu_busy_out(fu_busy_out), .cdb_req_out(cdb_req_out),
    .cdb_grant_in(cdb_grant_in), .cdb_value_out(cdb_value_out),
    .cdb_rob_ix_out(cdb_rob_ix_out), .drop_err_out(drop_err_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] ref_result(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    int     sa;
    int     sb;
    int     sh;
    longint prod;
    sa = a;
    sb = b;
    sh = int'(b % 32);
    prod = longint'(sa) * longint'(sb);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd6:    return (a < b) ? 32'd1 : 32'd0;
      4'd7:    return a << sh;
      4'd8:    return a >> sh;
      4'd9:    return 32'(sa >>> sh);
      4'd10:   return prod[31:0];
      default: return 32'd0;
    endcase
  endfunction

  // Transaction-level model: an accepted op becomes visible on the CDB a
  // fixed number of edges after acceptance and stays there until granted.
  int            cyc = 0;
  int            req_at = 0;
  logic          m_busy = 1'b0;
  logic          m_req = 1'b0;
  logic          m_drop = 1'b0;
  logic [31:0]   m_val = '0;
  logic [RW-1:0] m_tag = '0;
  logic [31:0]   m_pend = '0;

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      m_busy = 1'b0; m_req = 1'b0; m_drop = 1'b0; m_val = '0; m_tag = '0;
    end else begin
      cyc = cyc + 1;
      if (flush_in) begin
        m_busy = 1'b0;
        m_req  = 1'b0;
      end else if (m_busy) begin
        if (valid_in) m_drop = 1'b1;
        if (m_req && cdb_grant_in) begin
          m_busy = 1'b0;
          m_req  = 1'b0;
        end else if (!m_req && cyc == req_at) begin
          m_req = 1'b1;
          m_val = m_pend;
        end
      end else if (valid_in) begin
        m_busy = 1'b1;
        m_tag  = rob_ix_in;
        m_pend = ref_result(opcode_in, rval1_in, rval2_in);
        req_at = cyc + ((opcode_in == 4'd10) ? ML : 1) - 1;
        if (req_at == cyc) begin
          m_req = 1'b1;
          m_val = m_pend;
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (rst_in) begin
      check_output("model busy", 32'(fu_busy_out), 32'(m_busy));
      check_output("model req", 32'(cdb_req_out), 32'(m_req));
      check_output("model drop", 32'(drop_err_out), 32'(m_drop));
      if (m_req) begin
        check_output("model value", cdb_value_out, m_val);
        check_output("model tag", 32'(cdb_rob_ix_out), 32'(m_tag));
      end
    end
  end

  // Presents one op for a single cycle from an idle unit; returns at the
  // negedge following the accepting edge.
  task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [RW-1:0] tag,
                                input logic grant);
    @(negedge clk_in);
    valid_in = 1'b1; opcode_in = op; rval1_in = a; rval2_in = b;
    rob_ix_in = tag; cdb_grant_in = grant;
    @(negedge clk_in);
    valid_in = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'(int'($urandom_range(0, 40)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    $display("[TB] start");
    #23;
    check_output("reset busy", 32'(fu_busy_out), 32'd0);
    check_output("reset req", 32'(cdb_req_out), 32'd0);
    check_output("reset value", cdb_value_out, 32'd0);
    check_output("reset tag", 32'(cdb_rob_ix_out), 32'd0);
    check_output("reset drop", 32'(drop_err_out), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    check_output("idle busy", 32'(fu_busy_out), 32'd0);
    check_output("idle req", 32'(cdb_req_out), 32'd0);

    apply_stimulus(4'd0, 32'd5, 32'hFFFF_FFF9, 3'd3, 1'b1);
    check_output("add req", 32'(cdb_req_out), 32'd1);
    check_output("add value", cdb_value_out, 32'hFFFF_FFFE);
    check_output("add tag", 32'(cdb_rob_ix_out), 32'd3);
    @(negedge clk_in);
    check_output("add done req", 32'(cdb_req_out), 32'd0);
    check_output("add done busy", 32'(fu_busy_out), 32'd0);

    apply_stimulus(4'd9, 32'h8000_0010, 32'h0000_0024, 3'd1, 1'b1);
    check_output("sra value", cdb_value_out, 32'hF800_0001);
    check_output("sra tag", 32'(cdb_rob_ix_out), 32'd1);
    @(negedge clk_in);
    apply_stimulus(4'd6, 32'hFFFF_FFFF, 32'd1, 3'd2, 1'b1);
    check_output("sltu value", cdb_value_out, 32'd0);
    check_output("sltu tag", 32'(cdb_rob_ix_out), 32'd2);
    @(negedge clk_in);
    apply_stimulus(4'd5, 32'hFFFF_FFFF, 32'd1, 3'd4, 1'b1);
    check_output("slt value", cdb_value_out, 32'd1);
    check_output("slt tag", 32'(cdb_rob_ix_out), 32'd4);
    @(negedge clk_in);
    apply_stimulus(4'd12, 32'd9, 32'd9, 3'd7, 1'b1);
    check_output("illegal req", 32'(cdb_req_out), 32'd1);
    check_output("illegal value", cdb_value_out, 32'd0);
    @(negedge clk_in);

    // Mul with a stalled grant and a dropped dispatch during EXEC.
    apply_stimulus(4'd10, 32'hFFFF_FFFA, 32'd7, 3'd5, 1'b0);
    check_output("mul c1 req", 32'(cdb_req_out), 32'd0);
    check_output("mul c1 busy", 32'(fu_busy_out), 32'd1);
    valid_in = 1'b1; opcode_in = 4'd0; rob_ix_in = 3'd6;
    @(negedge clk_in);
    valid_in = 1'b0;
    check_output("mul c2 req", 32'(cdb_req_out), 32'd0);
    check_output("drop set", 32'(drop_err_out), 32'd1);
    @(negedge clk_in);
    check_output("mul c3 req", 32'(cdb_req_out), 32'd1);
    check_output("mul value", cdb_value_out, 32'hFFFF_FFD6);
    check_output("mul tag", 32'(cdb_rob_ix_out), 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check_output("mul stall req", 32'(cdb_req_out), 32'd1);
      check_output("mul stall value", cdb_value_out, 32'hFFFF_FFD6);
    end
    cdb_grant_in = 1'b1;
    @(negedge clk_in);
    cdb_grant_in = 1'b0;
    check_output("mul done req", 32'(cdb_req_out), 32'd0);
    check_output("mul done busy", 32'(fu_busy_out), 32'd0);

    apply_stimulus(4'd1, 32'd10, 32'd3, 3'd2, 1'b0);
    check_output("sub value", cdb_value_out, 32'd7);
    flush_in = 1'b1;
    @(negedge clk_in);
    flush_in = 1'b0;
    check_output("flush req", 32'(cdb_req_out), 32'd0);
    check_output("flush busy", 32'(fu_busy_out), 32'd0);
    check_output("drop sticky", 32'(drop_err_out), 32'd1);

    // Asynchronous reset between edges while the Mul is in EXEC.
    @(negedge clk_in);
    valid_in = 1'b1; opcode_in = 4'd10; rval1_in = 32'd3; rval2_in = 32'd4;
    rob_ix_in = 3'd1; cdb_grant_in = 1'b0;
    @(posedge clk_in);
    #1 valid_in = 1'b0;
    #2 rst_in = 1'b0;
    #1;
    check_output("async busy", 32'(fu_busy_out), 32'd0);
    check_output("async req", 32'(cdb_req_out), 32'd0);
    check_output("async value", cdb_value_out, 32'd0);
    check_output("async drop", 32'(drop_err_out), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    apply_stimulus(4'd0, 32'd1, 32'd2, 3'd6, 1'b1);
    check_output("post reset value", cdb_value_out, 32'd3);
    check_output("post reset tag", 32'(cdb_rob_ix_out), 32'd6);
    @(negedge clk_in);
    check_output("post reset idle", 32'(fu_busy_out), 32'd0);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk_in);
      valid_in     = ($urandom_range(0, 2) != 0);
      opcode_in    = ($urandom_range(0, 3) == 0) ? 4'd10 : 4'($urandom_range(0, 15));
      rval1_in     = pick_operand();
      rval2_in     = pick_operand();
      rob_ix_in    = RW'($urandom_range(0, 7));
      cdb_grant_in = ($urandom_range(0, 2) != 0);
      flush_in     = ($urandom_range(0, 19) == 0);
    end
    @(negedge clk_in);
    valid_in = 1'b0; flush_in = 1'b0; cdb_grant_in = 1'b0;
    repeat (2) @(negedge clk_in);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
